// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction prefetch stage.
//   fetch_state_t : prefetch FSM encoding (idle / request outstanding / stale request)
//   fetch_entry_t : one buffered instruction together with its fetch address
//   PC_STEP       : byte increment between sequential fetches
//   INST_NOP      : value presented on the instruction output when nothing is valid
package fetch_pkg;

  typedef enum logic [1:0] {
    FetchIdle    = 2'd0,
    FetchReq     = 2'd1,
    FetchDiscard = 2'd2
  } fetch_state_t;

  localparam logic [31:0] PC_STEP  = 32'd4;
  localparam logic [31:0] INST_NOP = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_prefetch_if.sv
// fetch_prefetch_if: bundles the instruction-memory handshake, the execute redirect and the
// decode handshake of the prefetch stage.
//   master : the prefetch stage (drives imem_req/imem_addr and the inst_* outputs)
//   slave  : the surroundings (memory, execute, decode)
interface fetch_prefetch_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  logic        redirect;
  logic [31:0] redirect_pc;

  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;

  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc,
    input  imem_ack, imem_rdata, redirect, redirect_pc, inst_ready
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc,
    output imem_ack, imem_rdata, redirect, redirect_pc, inst_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO of fetch_entry_t.
//   clk, rst      : clock, synchronous active-low reset
//   flush_i       : empties the FIFO; dominates push_i/pop_i
//   push_i        : write push_data_i (ignored when full unless popping the same cycle)
//   pop_i         : drop the head entry (ignored when empty)
//   head_o        : current head entry (meaningless when empty_o)
//   count_o       : number of stored entries
//   full_o/empty_o: occupancy flags
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  fetch_entry_t             push_data_i,
  input  logic                     pop_i,
  output fetch_entry_t             head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0] count_q;
  fetch_entry_t    mem_q [DEPTH];
  logic            do_push, do_pop;

  assign full_o  = (count_q == CntW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rptr_q];

  assign do_pop  = pop_i & ~empty_o;
  // A full FIFO can still take a push when the head leaves in the same cycle.
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk) begin
    if (!rst || flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_q + PtrW'(do_push);
      rptr_q  <= rptr_q + PtrW'(do_pop);
      count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  // Storage needs no reset: contents are only observed through count_q.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) begin
      mem_q[wptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/fetch_prefetch.sv
// fetch_prefetch: instruction prefetch stage in front of decode.
// Owns the PC, keeps at most one instruction-memory request outstanding, buffers returned
// words in fetch_fifo and hands them to decode with a valid/ready handshake. A redirect from
// execute flushes buffered words and turns an outstanding request into a stale one whose
// response is dropped.
//   clk, rst : clock, synchronous active-low reset
//   bus      : fetch_prefetch_if.master (imem_*, redirect*, inst_*)
// Build option: FETCH_BYPASS_EN -- when the FIFO is empty, a response is forwarded to decode
// in the cycle it arrives, and is not buffered if decode takes it immediately.
module fetch_prefetch
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic              clk,
  input  logic              rst,
  fetch_prefetch_if.master  bus
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;
  localparam logic [CntW:0] DepthExt = (CntW + 1)'(DEPTH);

  localparam logic [1:0] IDLE    = FetchIdle;
  localparam logic [1:0] REQ     = FetchReq;
  localparam logic [1:0] DISCARD = FetchDiscard;

  logic [1:0]      state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [31:0]     stale_q, stale_d;

  logic            ack;
  logic            bypass;
  logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
  fetch_entry_t    fifo_head, push_entry;
  logic [CntW-1:0] fifo_count;
  logic [CntW:0]   count_after;
  logic            unused_rpc;

  assign unused_rpc = ^bus.redirect_pc[1:0];

  // Request is a pure function of state, so it is low in reset and one cycle after release.
  assign bus.imem_req  = (state_q != IDLE);
  // While draining a stale request the old address must stay on the bus.
  assign bus.imem_addr = (state_q == DISCARD) ? stale_q : pc_q;

  assign ack        = bus.imem_ack & bus.imem_req;
  assign push_entry = '{pc: pc_q, inst: bus.imem_rdata};

`ifdef FETCH_BYPASS_EN
  assign bypass = fifo_empty & ~bus.redirect & ack & (state_q == REQ);
`else
  assign bypass = 1'b0;
`endif

  // Only the FIFO head can be popped; a bypassed word is consumed by not pushing it.
  assign fifo_pop  = ~fifo_empty & bus.inst_ready & ~bus.redirect;
  assign fifo_push = ack & (state_q == REQ) & ~bus.redirect & ~(bypass & bus.inst_ready);

  assign count_after = {1'b0, fifo_count} + (CntW + 1)'(fifo_push) - (CntW + 1)'(fifo_pop);

  always_comb begin
    if (bypass) begin
      bus.inst_valid = 1'b1;
      bus.inst       = bus.imem_rdata;
      bus.inst_pc    = pc_q;
    end else if (!fifo_empty) begin
      bus.inst_valid = 1'b1;
      bus.inst       = fifo_head.inst;
      bus.inst_pc    = fifo_head.pc;
    end else begin
      bus.inst_valid = 1'b0;
      bus.inst       = INST_NOP;
      bus.inst_pc    = 32'h0;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    stale_d = stale_q;
    if (bus.redirect) begin
      pc_d = {bus.redirect_pc[31:2], 2'b00};
      case (state_q)
        REQ: begin
          if (ack) begin
            state_d = IDLE;
          end else begin
            state_d = DISCARD;
            stale_d = pc_q;
          end
        end
        DISCARD: begin
          if (ack) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifo_full) state_d = REQ;
        end
        REQ: begin
          if (ack) begin
            pc_d    = pc_q + PC_STEP;
            state_d = (count_after < DepthExt) ? REQ : IDLE;
          end
        end
        DISCARD: begin
          if (ack) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      stale_q <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      stale_q <= stale_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (bus.redirect),
    .push_i      (fifo_push),
    .push_data_i (push_entry),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .count_o     (fifo_count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

endmodule
